// File: rtl/eth_out_arb.sv
// Two-source packet arbiter: round-robin on ties, whole packets,
// one-cycle registered output with downstream stall.
module eth_out_arb (
    input  logic        clk,
    input  logic        resetN,
    input  logic        reqA,
    input  logic [31:0] inDataA,
    input  logic        inSopA,
    input  logic        inEopA,
    output logic        popA,
    input  logic        reqB,
    input  logic [31:0] inDataB,
    input  logic        inSopB,
    input  logic        inEopB,
    output logic        popB,
    input  logic        outStall,
    output logic [31:0] outData,
    output logic        outSop,
    output logic        outEop,
    output logic        outValid,
    output logic        grantA,
    output logic        grantB,
    output logic [15:0] pktCntA,
    output logic [15:0] pktCntB,
    output logic        errSop
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] GRANT_A = 2'd1;
    localparam logic [1:0] GRANT_B = 2'd2;

    logic [1:0]  state;
    logic        lastB;
    logic        firstWord;
    logic        pop;
    logic [31:0] selData;
    logic        selSop;
    logic        selEop;

    assign grantA = (state == GRANT_A);
    assign grantB = (state == GRANT_B);

    // Pops are gated by reset so nothing is consumed while held in reset.
    assign popA = resetN & grantA & reqA & ~outStall;
    assign popB = resetN & grantB & reqB & ~outStall;
    assign pop  = popA | popB;

    assign selData = grantB ? inDataB : inDataA;
    assign selSop  = grantB ? inSopB  : inSopA;
    assign selEop  = grantB ? inEopB  : inEopA;

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state     <= IDLE;
            lastB     <= 1'b1;
            firstWord <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    firstWord <= 1'b1;
                    if (reqA && (!reqB || lastB))
                        state <= GRANT_A;
                    else if (reqB)
                        state <= GRANT_B;
                end
                GRANT_A, GRANT_B: begin
                    if (pop) begin
                        firstWord <= 1'b0;
                        if (selEop) begin
                            state <= IDLE;
                            lastB <= grantB;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            outData  <= 32'd0;
            outSop   <= 1'b0;
            outEop   <= 1'b0;
            outValid <= 1'b0;
        end else if (!outStall) begin
            outValid <= pop;
            if (pop) begin
                outData <= selData;
                outSop  <= selSop;
                outEop  <= selEop;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            pktCntA <= 16'd0;
            pktCntB <= 16'd0;
        end else begin
            if (popA && inEopA && pktCntA != 16'hFFFF)
                pktCntA <= pktCntA + 16'd1;
            if (popB && inEopB && pktCntB != 16'hFFFF)
                pktCntB <= pktCntB + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN)
            errSop <= 1'b0;
        else if (pop && firstWord && !selSop)
            errSop <= 1'b1;
    end

endmodule

// File: tb/tb_eth_out_arb.sv
// Randomised bench for eth_out_arb: packet-level sources, spec model,
// scoreboard queue drained by an independent output monitor.
module tb_eth_out_arb;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        reqA = 1'b0, reqB = 1'b0;
    logic [31:0] inDataA = '0, inDataB = '0;
    logic        inSopA = 1'b0, inEopA = 1'b0;
    logic        inSopB = 1'b0, inEopB = 1'b0;
    logic        popA, popB;
    logic        outStall = 1'b0;
    logic [31:0] outData;
    logic        outSop, outEop, outValid;
    logic        grantA, grantB;
    logic [15:0] pktCntA, pktCntB;
    logic        errSop;

    eth_out_arb dut (
        .clk(clk), .resetN(resetN),
        .reqA(reqA), .inDataA(inDataA), .inSopA(inSopA),
        .inEopA(inEopA), .popA(popA),
        .reqB(reqB), .inDataB(inDataB), .inSopB(inSopB),
        .inEopB(inEopB), .popB(popB),
        .outStall(outStall), .outData(outData),
        .outSop(outSop), .outEop(outEop), .outValid(outValid),
        .grantA(grantA), .grantB(grantB),
        .pktCntA(pktCntA), .pktCntB(pktCntB), .errSop(errSop)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] d;
        logic        s;
        logic        e;
    } word_t;

    word_t srcA[$];
    word_t srcB[$];
    word_t sbQ[$];

    int vecs = 0;
    int errs = 0;

    // Reference model: owner 0 = nobody, 1 = A, 2 = B.
    int owner = 0;
    bit mLastB = 1'b1;
    bit mFirst = 1'b0;
    bit mErr = 1'b0;
    int mCntA = 0;
    int mCntB = 0;
    bit expPopA = 1'b0;
    bit expPopB = 1'b0;
    logic [34:0] held = '0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s actual=%h required=%h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic addPkt(input int src, input int len, input bit badSop);
        word_t w;
        for (int i = 0; i < len; i++) begin
            w.d = $urandom;
            w.s = (i == 0) && !badSop;
            w.e = (i == len - 1);
            if (src == 0) srcA.push_back(w);
            else srcB.push_back(w);
        end
    endtask

    task automatic cycle(input bit rst, input int stallPct, input int gapPct);
        word_t w;
        @(negedge clk);
        resetN   = !rst;
        outStall = ($urandom_range(99) < stallPct);
        reqA = (srcA.size() > 0) && ($urandom_range(99) >= gapPct);
        reqB = (srcB.size() > 0) && ($urandom_range(99) >= gapPct);
        if (srcA.size() > 0) {inDataA, inSopA, inEopA} = srcA[0];
        else {inDataA, inSopA, inEopA} = {$urandom, 2'b00};
        if (srcB.size() > 0) {inDataB, inSopB, inEopB} = srcB[0];
        else {inDataB, inSopB, inEopB} = {$urandom, 2'b00};
        #1;
        expPopA = resetN && owner == 1 && reqA && !outStall;
        expPopB = resetN && owner == 2 && reqB && !outStall;
        check("pop", {popA, popB}, {expPopA, expPopB});
        @(posedge clk);
        if (!resetN) begin
            owner = 0; mLastB = 1'b1; mFirst = 1'b0; mErr = 1'b0;
            mCntA = 0; mCntB = 0;
            srcA.delete(); srcB.delete(); sbQ.delete();
        end else if (owner == 0) begin
            mFirst = 1'b1;
            if (reqA && (!reqB || mLastB)) owner = 1;
            else if (reqB) owner = 2;
        end else if (expPopA || expPopB) begin
            w = expPopA ? srcA.pop_front() : srcB.pop_front();
            sbQ.push_back(w);
            if (mFirst && !w.s) mErr = 1'b1;
            mFirst = 1'b0;
            if (w.e) begin
                if (owner == 1 && mCntA < 65535) mCntA++;
                if (owner == 2 && mCntB < 65535) mCntB++;
                mLastB = (owner == 2);
                owner = 0;
            end
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((srcA.size() + srcB.size() > 0 || owner != 0) && n < 300) begin
            cycle(0, 0, 0);
            n++;
        end
        check("drain", srcA.size() + srcB.size(), 0);
    endtask

    // Output monitor: consumes one scoreboard entry per loaded output word.
    always @(posedge clk) begin
        word_t w;
        #1;
        if (!resetN) begin
            check("rst_data", outData, 32'd0);
            check("rst_flags", {outValid, outSop, outEop, grantA, grantB,
                                errSop, pktCntA, pktCntB}, 38'd0);
            held = '0;
        end else begin
            if (outStall) begin
                check("stall_hold", {outValid, outSop, outEop, outData}, held);
            end else if (sbQ.size() > 0) begin
                w = sbQ.pop_front();
                check("out_word", {outValid, outSop, outEop, outData},
                      {1'b1, w.s, w.e, w.d});
            end else begin
                check("out_idle", outValid, 1'b0);
            end
            held = {outValid, outSop, outEop, outData};
            check("grant", {grantA, grantB}, {owner == 1, owner == 2});
            check("pktCnt", {pktCntA, pktCntB}, {mCntA[15:0], mCntB[15:0]});
            check("errSop", errSop, mErr);
        end
    end

    initial begin
        word_t w;
        repeat (2) cycle(1, 0, 0);

        w = '{32'h0000ABCD, 1'b1, 1'b0}; srcA.push_back(w);
        w = '{32'h76543210, 1'b0, 1'b0}; srcA.push_back(w);
        w = '{32'h99999999, 1'b0, 1'b1}; srcA.push_back(w);
        repeat (7) cycle(0, 0, 0);
        check("single_cntA", pktCntA, 16'd1);

        repeat (2) begin
            addPkt(0, 2, 0);
            addPkt(1, 2, 0);
        end
        drain();
        repeat (2) cycle(0, 0, 0);

        repeat (400) begin
            if (srcA.size() < 6 && $urandom_range(3) == 0)
                addPkt(0, $urandom_range(1, 4), 0);
            if (srcB.size() < 6 && $urandom_range(3) == 0)
                addPkt(1, $urandom_range(1, 4), 0);
            cycle(0, 25, 20);
        end
        drain();

        addPkt(0, 3, 1);
        addPkt(1, 1, 0);
        repeat (60) begin
            if (srcA.size() < 4 && $urandom_range(4) == 0)
                addPkt(0, $urandom_range(1, 3), 0);
            cycle(0, 10, 10);
        end
        drain();
        check("errSop_sticky", errSop, 1'b1);

        addPkt(0, 4, 0);
        for (int i = 0; i < 50 && !(owner == 1 && srcA.size() < 3); i++)
            cycle(0, 0, 0);
        cycle(1, 0, 0);
        cycle(0, 0, 0);
        repeat (2) begin
            addPkt(0, 2, 0);
            addPkt(1, 3, 0);
        end
        drain();
        repeat (3) cycle(0, 0, 0);

        @(posedge clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
